// File: rtl/orpsoc_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : orpsoc_reset_sequencer
//  Description : Reset/boot sequencer for the multi-core OR1K SoC.
//                Synchronises an asynchronous active-low reset, holds the
//                wishbone fabric in reset for a fixed time, waits for the
//                program image to be loaded, then releases the cores in
//                index order, STAGGER_CYCLES apart. Once running, each core
//                can be given a fixed-length debug reset pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   wb_clk_i        in   1          system clock, rising edge
//   wb_rst_n_i      in   1          async active-low reset (sync deassert)
//   load_done_i     in   1          program image loaded (level)
//   core_en_i       in   NUM_CORES  per-core start enable (level)
//   core_rst_req_i  in   NUM_CORES  per-core debug reset request (pulse)
//   wb_rst_o        out  1          active-high fabric/memory reset
//   core_rst_o      out  NUM_CORES  active-high per-core reset
//   seq_done_o      out  1          boot sequence has reached RUN
// ============================================================================
module orpsoc_reset_sequencer #(
   parameter int NUM_CORES       = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int BUS_HOLD_CYCLES = 16,
   parameter int STAGGER_CYCLES  = 8,
   parameter int CORE_RST_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_n_i,
   input  logic                 load_done_i,
   input  logic [NUM_CORES-1:0] core_en_i,
   input  logic [NUM_CORES-1:0] core_rst_req_i,
   output logic                 wb_rst_o,
   output logic [NUM_CORES-1:0] core_rst_o,
   output logic                 seq_done_o
);

   // Core index width; a single-core build still needs a one-bit index.
   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

   // Counters run down to zero, so each load value is "cycles - 1".
   localparam logic [CNT_W-1:0] BUS_LOAD     = CNT_W'(BUS_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] CORE_LOAD    = CNT_W'(CORE_RST_CYCLES - 1);

   localparam logic [2:0] S_HOLD      = 3'd0;
   localparam logic [2:0] S_BUS       = 3'd1;
   localparam logic [2:0] S_WAIT_LOAD = 3'd2;
   localparam logic [2:0] S_RELEASE   = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   rst_s;
   logic [2:0]             state;
   logic [CNT_W-1:0]       cnt;
   logic [IDX_W-1:0]       idx;
   logic [CNT_W-1:0]       dbg_cnt [NUM_CORES];
   logic [NUM_CORES-1:0]   dbg_active;

   // ------------------------------------------------------------------------
   // Reset synchroniser: asserts immediately with wb_rst_n_i, deasserts only
   // after SYNC_STAGES clean edges so the FSM never sees a metastable release.
   // ------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_s = ~sync_chain[SYNC_STAGES-1];

   // ------------------------------------------------------------------------
   // Boot sequencer. All outputs are registered here so the downstream
   // SoC never sees combinational decode glitches on its reset lines.
   // ------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state      <= S_HOLD;
         cnt        <= '0;
         idx        <= '0;
         wb_rst_o   <= 1'b1;
         core_rst_o <= '1;
         seq_done_o <= 1'b0;
         dbg_active <= '0;
         for (int k = 0; k < NUM_CORES; k++) begin
            dbg_cnt[k] <= '0;
         end
      end else begin
         case (state)
            S_HOLD: begin
               if (!rst_s) begin
                  state <= S_BUS;
                  cnt   <= BUS_LOAD;
               end
            end

            S_BUS: begin
               wb_rst_o <= 1'b1;
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  wb_rst_o <= 1'b0;
                  state    <= S_WAIT_LOAD;
               end
            end

            S_WAIT_LOAD: begin
               // Once the image is seen the sequence commits; a later drop
               // of load_done_i is deliberately ignored.
               if (load_done_i) begin
                  state <= S_RELEASE;
                  idx   <= '0;
                  cnt   <= '0;
               end
            end

            S_RELEASE: begin
               // Cores already passed over while disabled are released as
               // soon as their enable appears; they do not wait for a slot.
               for (int k = 0; k < NUM_CORES; k++) begin
                  if ((k < int'(idx)) && core_en_i[k]) begin
                     core_rst_o[k] <= 1'b0;
                  end
               end
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  // A disabled core costs a single cycle and no stagger gap.
                  if (core_en_i[idx]) begin
                     core_rst_o[idx] <= 1'b0;
                     cnt             <= STAGGER_LOAD;
                  end
                  if (idx == LAST_IDX) begin
                     state <= S_RUN;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end

            S_RUN: begin
               seq_done_o <= 1'b1;
               for (int k = 0; k < NUM_CORES; k++) begin
                  if (core_rst_req_i[k]) begin
                     // New request (or retrigger) restarts the full pulse.
                     core_rst_o[k] <= 1'b1;
                     dbg_active[k] <= 1'b1;
                     dbg_cnt[k]    <= CORE_LOAD;
                  end else if (dbg_active[k]) begin
                     if (dbg_cnt[k] != '0) begin
                        dbg_cnt[k] <= dbg_cnt[k] - 1'b1;
                     end else begin
                        dbg_active[k] <= 1'b0;
                        // A disabled core stays held until enabled.
                        if (core_en_i[k]) begin
                           core_rst_o[k] <= 1'b0;
                        end
                     end
                  end else if (core_en_i[k]) begin
                     // Late enable of a core that was never released.
                     core_rst_o[k] <= 1'b0;
                  end
               end
            end

            default: begin
               state <= S_HOLD;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
